// File: rtl/vport_capture_st.sv
// Generic first-word fall-through FIFO; popDat shows the head entry whenever !empty.
// Latency: a push is visible at popDat on the cycle after it is written.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module vport_capture_fifo #(
    parameter int W     = 25,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         push,
    input  logic [W-1:0] pushDat,
    input  logic         pop,
    output logic [W-1:0] popDat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          doPush;
    logic          doPop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign popDat = mem[rdPtr];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushDat;
    end
endmodule

// Captures RGB888+VS/DE video into a start/dv/ready stream and measures active width/height.
// Latency: pixel at the inputs in cycle N is on oST_DATA in cycle N+2 (empty FIFO, ACTIVE).
// Backpressure: iST_READY stalls the FIFO; a push into a full FIFO drops the rest of the frame.
module vport_capture_st #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 12,
    parameter int VS_POL     = 1
) (
    input  logic             iCLK,
    input  logic             iRESETn,
    input  logic [7:0]       iRED,
    input  logic [7:0]       iGRN,
    input  logic [7:0]       iBLU,
    input  logic             iHS,
    input  logic             iVS,
    input  logic             iDE,
    input  logic             iENABLE,
    input  logic             iOVF_CLR,
    output logic [23:0]      oST_DATA,
    output logic             oST_START,
    output logic             oST_DV,
    input  logic             iST_READY,
    output logic [CNT_W-1:0] oWIDTH,
    output logic [CNT_W-1:0] oHEIGHT,
    output logic             oOVERFLOW,
    output logic             oBUSY
);
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DROP} stateT;

    localparam logic             VS_ACT  = (VS_POL != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stateT             state;
    stateT             stateNxt;
    logic [23:0]       rgbQ;
    logic              deQ;
    logic              dePrev;
    logic              vsQ;
    logic              vsPrev;
    logic              vsEdge;
    logic              deFall;
    logic              startFlag;
    logic              armStart;
    logic              fifoPush;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [24:0]       fifoDat;
    logic              stPop;
    logic              ovfSet;
    logic [CNT_W-1:0]  pixCnt;
    logic [CNT_W-1:0]  lineCnt;
    logic [CNT_W-1:0]  lineInc;
    logic              unusedHs;

    assign unusedHs = iHS;

    // VS history resets to the active level so a sync already asserted at release is not an edge.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            rgbQ   <= '0;
            deQ    <= 1'b0;
            dePrev <= 1'b0;
            vsQ    <= VS_ACT;
            vsPrev <= VS_ACT;
        end else begin
            rgbQ   <= {iRED, iGRN, iBLU};
            deQ    <= iDE;
            dePrev <= deQ;
            vsQ    <= iVS;
            vsPrev <= vsQ;
        end
    end

    assign vsEdge = (vsQ == VS_ACT) && (vsPrev != VS_ACT);
    assign deFall = dePrev && !deQ;

    assign oST_DV    = !fifoEmpty;
    assign stPop     = oST_DV && iST_READY;
    assign oST_DATA  = oST_DV ? fifoDat[23:0] : 24'h0;
    assign oST_START = oST_DV && fifoDat[24];
    assign oBUSY     = (state == ACTIVE) || (state == DROP);

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) state <= IDLE;
        else          state <= stateNxt;
    end

    always_comb begin
        stateNxt = state;
        armStart = 1'b0;
        fifoPush = 1'b0;
        ovfSet   = 1'b0;
        case (state)
            IDLE: begin
                if (iENABLE) stateNxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (!iENABLE) begin
                    stateNxt = IDLE;
                end else if (vsEdge) begin
                    stateNxt = ACTIVE;
                    armStart = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsEdge) begin
                    if (iENABLE) armStart = 1'b1;
                    else         stateNxt = IDLE;
                end else if (deQ) begin
                    // A pop in the same cycle frees the slot, so full alone is not an overflow.
                    if (fifoFull && !stPop) begin
                        stateNxt = DROP;
                        ovfSet   = 1'b1;
                    end else begin
                        fifoPush = 1'b1;
                    end
                end
            end
            DROP: begin
                if (vsEdge) begin
                    if (iENABLE) begin
                        stateNxt = ACTIVE;
                        armStart = 1'b1;
                    end else begin
                        stateNxt = IDLE;
                    end
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            startFlag <= 1'b0;
            oOVERFLOW <= 1'b0;
        end else begin
            if (armStart)      startFlag <= 1'b1;
            else if (fifoPush) startFlag <= 1'b0;
            if (ovfSet)        oOVERFLOW <= 1'b1;
            else if (iOVF_CLR) oOVERFLOW <= 1'b0;
        end
    end

    vport_capture_fifo #(
        .W     (25),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk     (iCLK),
        .rstN    (iRESETn),
        .push    (fifoPush),
        .pushDat ({startFlag, rgbQ}),
        .pop     (stPop),
        .popDat  (fifoDat),
        .empty   (fifoEmpty),
        .full    (fifoFull)
    );

    // A line ending on the same cycle as the VS edge still counts toward that frame.
    always_comb begin
        lineInc = lineCnt;
        if (deFall && lineCnt != CNT_MAX) lineInc = lineCnt + 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            pixCnt  <= '0;
            lineCnt <= '0;
            oWIDTH  <= '0;
            oHEIGHT <= '0;
        end else begin
            if (deFall) begin
                oWIDTH <= pixCnt;
                pixCnt <= '0;
            end else if (deQ && pixCnt != CNT_MAX) begin
                pixCnt <= pixCnt + 1'b1;
            end
            if (vsEdge) begin
                oHEIGHT <= lineInc;
                lineCnt <= '0;
            end else begin
                lineCnt <= lineInc;
            end
        end
    end
endmodule

// File: tb/tb_vport_capture_st.sv
// Scoreboard bench for vport_capture_st: stimulus pushes expected beats, a monitor pops/compares.
module tb_vport_capture_st;
    logic        iCLK;
    logic        iRESETn;
    logic [7:0]  iRED, iGRN, iBLU;
    logic        iHS, iVS, iDE;
    logic        iENABLE, iOVF_CLR;
    logic [23:0] oST_DATA;
    logic        oST_START, oST_DV;
    logic        iST_READY;
    logic [11:0] oWIDTH, oHEIGHT;
    logic        oOVERFLOW, oBUSY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beats = 0;
    int expLeft;
    bit expFirst;
    int firstDeCyc;
    int lastStartCyc;
    logic [1:0]  readyMode;
    logic        togBit;
    logic [24:0] sb [$];

    logic        stallPrev;
    logic [23:0] prevData;
    logic        prevStart;

    vport_capture_st #(.FIFO_DEPTH(16), .CNT_W(12), .VS_POL(1)) dut (
        .iCLK(iCLK), .iRESETn(iRESETn),
        .iRED(iRED), .iGRN(iGRN), .iBLU(iBLU),
        .iHS(iHS), .iVS(iVS), .iDE(iDE),
        .iENABLE(iENABLE), .iOVF_CLR(iOVF_CLR),
        .oST_DATA(oST_DATA), .oST_START(oST_START), .oST_DV(oST_DV),
        .iST_READY(iST_READY),
        .oWIDTH(oWIDTH), .oHEIGHT(oHEIGHT),
        .oOVERFLOW(oOVERFLOW), .oBUSY(oBUSY)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) cyc <= cyc + 1;

    initial begin
        togBit = 1'b0;
        forever begin
            @(posedge iCLK);
            #1 togBit = ~togBit;
        end
    end

    assign iST_READY = (readyMode == 2'd2) ? togBit : readyMode[0];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: compare each accepted beat with the scoreboard head; also check hold-while-stalled.
    always @(negedge iCLK) begin
        if (!iRESETn) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                total++;
                if (!oST_DV || oST_DATA !== prevData || oST_START !== prevStart) begin
                    bad++;
                    $display("FAIL stall_hold: got dv=%0b start=%0b data=%06h want dv=1 start=%0b data=%06h",
                             oST_DV, oST_START, oST_DATA, prevStart, prevData);
                end
            end
            if (oST_DV && iST_READY) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got start=%0b data=%06h want no beat", oST_START, oST_DATA);
                end else begin
                    logic [24:0] e;
                    e = sb.pop_front();
                    if ({oST_START, oST_DATA} !== e) begin
                        bad++;
                        $display("FAIL beat: got start=%0b data=%06h want start=%0b data=%06h",
                                 oST_START, oST_DATA, e[24], e[23:0]);
                    end
                end
                beats++;
                if (oST_START) lastStartCyc = cyc;
            end
            stallPrev = oST_DV && !iST_READY;
            prevData  = oST_DATA;
            prevStart = oST_START;
        end
    end

    function automatic logic [23:0] pix(input int id, input int x, input int y);
        logic [7:0] a, b, c;
        a = id[7:0];
        b = x[7:0];
        c = y[7:0];
        return {a, b ^ 8'h5A, c + 8'h30};
    endfunction

    task automatic drive(input logic de, input logic vs, input logic hs, input logic [23:0] rgb);
        iDE  = de;
        iVS  = vs;
        iHS  = hs;
        iRED = rgb[23:16];
        iGRN = rgb[15:8];
        iBLU = rgb[7:0];
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_pix(input int id, input int x, input int y);
        logic [23:0] p;
        p = pix(id, x, y);
        if (expLeft > 0) begin
            if (expFirst) firstDeCyc = cyc;
            sb.push_back({expFirst, p});
            expFirst = 1'b0;
            expLeft--;
        end
        drive(1'b1, 1'b0, 1'b0, p);
    endtask

    task automatic hblank();
        for (int b = 0; b < 4; b++) drive(1'b0, 1'b0, (b < 2), 24'h0);
    endtask

    task automatic lines(input int id, input int w, input int y0, input int y1);
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < w; x++) drive_pix(id, x, y);
            hblank();
        end
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b1, 1'b0, 24'h0);
        drive(1'b0, 1'b1, 1'b0, 24'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge iCLK);
            #1;
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        int b0;
        iRESETn   = 1'b0;
        iRED = 8'h0; iGRN = 8'h0; iBLU = 8'h0;
        iHS = 1'b0; iVS = 1'b0; iDE = 1'b0;
        iENABLE   = 1'b0;
        iOVF_CLR  = 1'b0;
        readyMode = 2'd1;
        expLeft   = 0;
        expFirst  = 1'b0;
        firstDeCyc   = 0;
        lastStartCyc = 0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_dv", oST_DV, 0);
        check("rst_start", oST_START, 0);
        check("rst_data", oST_DATA, 0);
        check("rst_width", oWIDTH, 0);
        check("rst_height", oHEIGHT, 0);
        check("rst_ovf", oOVERFLOW, 0);
        check("rst_busy", oBUSY, 0);

        // 8x4 frame, always ready
        iRESETn = 1'b1;
        iENABLE = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
        vs_pulse();
        beats = 0;
        expLeft = 32; expFirst = 1'b1;
        lines(1, 8, 0, 4);
        vs_pulse();
        drain("t1_drain");
        check("t1_beats", beats, 32);
        check("t1_width", oWIDTH, 8);
        check("t1_height", oHEIGHT, 4);
        check("t1_latency", lastStartCyc - firstDeCyc, 2);
        check("t1_busy", oBUSY, 1);

        // Disable at a frame boundary, then enable mid-frame: nothing until the next VS
        iENABLE = 1'b0;
        vs_pulse();
        check("t2_busy_off", oBUSY, 0);
        b0 = beats;
        lines(2, 8, 0, 2);
        iENABLE = 1'b1;
        lines(2, 8, 2, 4);
        check("t2_no_beats", beats, b0);
        vs_pulse();
        expLeft = 32; expFirst = 1'b1;
        lines(3, 8, 0, 4);
        vs_pulse();
        drain("t2_drain");
        check("t2_beats", beats, b0 + 32);

        // Ready toggling each cycle on a 16-pixel line
        b0 = beats;
        expLeft = 16; expFirst = 1'b1;
        readyMode = 2'd2;
        lines(4, 16, 0, 1);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 24'h0);
        readyMode = 2'd1;
        drain("t3_drain");
        check("t3_beats", beats, b0 + 16);
        check("t3_ovf", oOVERFLOW, 0);
        check("t3_width", oWIDTH, 16);

        // Sink stalled for a 40-pixel frame: 16 kept, rest dropped
        vs_pulse();
        readyMode = 2'd0;
        b0 = beats;
        expLeft = 16; expFirst = 1'b1;
        lines(5, 8, 0, 5);
        check("t4_ovf", oOVERFLOW, 1);
        check("t4_busy_drop", oBUSY, 1);
        check("t4_dv_held", oST_DV, 1);
        readyMode = 2'd1;
        drain("t4_drain");
        check("t4_beats", beats, b0 + 16);
        vs_pulse();
        check("t4_width", oWIDTH, 8);
        check("t4_height", oHEIGHT, 5);
        expLeft = 16; expFirst = 1'b1;
        lines(6, 8, 0, 2);
        drain("t4_next_drain");
        check("t4_ovf_sticky", oOVERFLOW, 1);
        iOVF_CLR = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        iOVF_CLR = 1'b0;
        check("t4_ovf_clr", oOVERFLOW, 0);

        // Fill to 16, then push and pop together while full
        vs_pulse();
        readyMode = 2'd0;
        b0 = beats;
        expLeft = 20; expFirst = 1'b1;
        for (int x = 0; x < 20; x++) begin
            if (x == 17) readyMode = 2'd1;
            drive_pix(9, x, 0);
        end
        hblank();
        drain("t5_drain");
        check("t5_beats", beats, b0 + 20);
        check("t5_ovf", oOVERFLOW, 0);
        check("t5_width", oWIDTH, 20);

        // Reset pulse mid-frame
        vs_pulse();
        readyMode = 2'd0;
        b0 = beats;
        expLeft = 0;
        lines(7, 8, 0, 1);
        for (int x = 0; x < 3; x++) drive_pix(7, x, 1);
        check("t6_dv_before", oST_DV, 1);
        iRESETn = 1'b0;
        #1;
        check("t6_dv_rst", oST_DV, 0);
        check("t6_width_rst", oWIDTH, 0);
        check("t6_busy_rst", oBUSY, 0);
        #1;
        for (int x = 3; x < 5; x++) drive_pix(7, x, 1);
        iRESETn = 1'b1;
        readyMode = 2'd1;
        for (int x = 5; x < 8; x++) drive_pix(7, x, 1);
        hblank();
        lines(7, 8, 2, 4);
        check("t6_no_beats", beats, b0);
        vs_pulse();
        check("t6_height_partial", oHEIGHT, 3);
        expLeft = 32; expFirst = 1'b1;
        lines(8, 8, 0, 4);
        vs_pulse();
        drain("t6_drain");
        check("t6_beats", beats, b0 + 32);
        check("t6_height", oHEIGHT, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
